// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: FSM and TX-phase
// encodings, command codes, and the frame-width derivation.
package spi_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // A frame is the 2-bit command followed by the payload.
    function automatic int word_w(input int addr_size);
        return addr_size + 2;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    typedef enum logic [1:0] {
        TX_GUARD,
        TX_WAIT,
        TX_SHIFT,
        TX_DONE
    } tx_phase_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into {cmd, payload} words
// with a one-cycle rx_valid strobe, and serialises RAM read data onto MISO.
// Ports: clk, rst_n (sync, active low), SS_n, MOSI, MISO,
//        rx_data/rx_valid (to RAM), tx_data/tx_valid (from RAM).
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_W    = word_w(ADDR_SIZE),
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [WORD_W-1:0]    rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(ADDR_SIZE);

    state_e                state;
    tx_phase_e             tx_phase;
    logic [CNT_W-1:0]      cnt;
    logic [WORD_W-2:0]     rx_sr;
    logic [ADDR_SIZE-1:0]  tx_sr;
    logic                  rx_done;
    logic                  rd_addr_seen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_phase     <= TX_GUARD;
            cnt          <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            rx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
        end else if (state != IDLE && SS_n) begin
            // Frame abort: rd_addr_seen is deliberately left alone.
            state    <= IDLE;
            tx_phase <= TX_GUARD;
            cnt      <= '0;
            rx_done  <= 1'b0;
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (!SS_n) begin
                        state <= CHK_CMD;
                        cnt   <= '0;
                    end
                end
                CHK_CMD: begin
                    rx_sr   <= {{(WORD_W-2){1'b0}}, MOSI};
                    cnt     <= CNT_W'(1);
                    rx_done <= 1'b0;
                    if (!MOSI)
                        state <= WRITE;
                    else if (rd_addr_seen)
                        state <= READ_DATA;
                    else
                        state <= READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!rx_done) begin
                        rx_sr <= {rx_sr[WORD_W-3:0], MOSI};
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_RX) begin
                            rx_data  <= {rx_sr, MOSI};
                            rx_valid <= 1'b1;
                            rx_done  <= 1'b1;
                            cnt      <= '0;
                            tx_phase <= TX_GUARD;
                            if (state == READ_ADD)
                                rd_addr_seen <= 1'b1;
                        end
                    end else if (state == READ_DATA) begin
                        unique case (tx_phase)
                            // RAM needs a cycle; tx_valid here may be stale.
                            TX_GUARD: tx_phase <= TX_WAIT;
                            TX_WAIT: begin
                                if (tx_valid) begin
                                    MISO     <= tx_data[ADDR_SIZE-1];
                                    tx_sr    <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                                    cnt      <= CNT_W'(1);
                                    tx_phase <= TX_SHIFT;
                                end
                            end
                            TX_SHIFT: begin
                                if (cnt == LAST_TX) begin
                                    MISO         <= 1'b0;
                                    rd_addr_seen <= 1'b0;
                                    tx_phase     <= TX_DONE;
                                end else begin
                                    MISO  <= tx_sr[ADDR_SIZE-1];
                                    tx_sr <= {tx_sr[ADDR_SIZE-2:0], 1'b0};
                                    cnt   <= cnt + 1'b1;
                                end
                            end
                            TX_DONE: MISO <= 1'b0;
                            default: tx_phase <= TX_DONE;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
